// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e                 : framer FSM states
//   UART_DATA_BITS             : payload bits per frame (8N1)
//   UART_CLKS_PER_BIT_DEFAULT  : 50 MHz / 115200 baud
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART receiver.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset, clears the counter
//   load_half : load the half-period delay (start-bit centring)
//   enable    : count down while high
//   tick      : one-cycle strobe; the consumer samples the line on this edge
// After a tick the counter reloads a full period, so successive samples are
// spaced exactly CLKS_PER_BIT cycles apart with no accumulated drift.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic load_half,
    input  logic enable,
    output logic tick
);

    // Counter only ever holds values up to CLKS_PER_BIT-1, which $clog2 covers.
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (load_half) begin
            cnt_d = HALF_LOAD;
        end else if (enable) begin
            if (cnt_q == '0) begin
                tick  = 1'b1;
                cnt_d = FULL_LOAD;
            end else begin
                cnt_d = cnt_q - TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// UART 8N1 receive framer (LSB first).
//   clkIn           : system clock, rising edge
//   resetIn         : asynchronous active-high reset
//   rxIn            : filtered, synchronised serial line, idle high
//   ackIn           : consumer acknowledge, clears dataValidOut
//   dataOut         : last accepted byte
//   dataValidOut    : byte pending in dataOut until acknowledged
//   frameErrorOut   : one-cycle pulse, stop bit sampled low
//   overrunErrorOut : one-cycle pulse, new frame dropped while a byte pending
//   busyOut         : high whenever the FSM is not in IDLE
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clkIn,
    input  logic       resetIn,
    input  logic       rxIn,
    input  logic       ackIn,
    output logic [7:0] dataOut,
    output logic       dataValidOut,
    output logic       frameErrorOut,
    output logic       overrunErrorOut,
    output logic       busyOut
);

    localparam int unsigned IW = $clog2(UART_DATA_BITS);

    rx_state_e                   state_q, state_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [UART_DATA_BITS-1:0]   data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        ferr_q, ferr_d;
    logic                        oerr_q, oerr_d;
    logic                        busy_q, busy_d;

    logic load_half;
    logic timer_en;
    logic tick;

    assign timer_en = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clkIn),
        .rst      (resetIn),
        .load_half(load_half),
        .enable   (timer_en),
        .tick     (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        oerr_d    = 1'b0;
        load_half = 1'b0;

        if (ackIn && valid_q) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rxIn) begin
                    state_d   = ST_START;
                    load_half = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rxIn) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {rxIn, shift_q[UART_DATA_BITS-1:1]};
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IW'(UART_DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rxIn) begin
                        // An ack arriving with the stop sample frees the slot
                        // in the same cycle, so the new byte is accepted.
                        if (!valid_q || ackIn) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            oerr_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rxIn) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
            busy_q  <= busy_d;
        end
    end

    assign dataOut         = data_q;
    assign dataValidOut    = valid_q;
    assign frameErrorOut   = ferr_q;
    assign overrunErrorOut = oerr_q;
    assign busyOut         = busy_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer with CLKS_PER_BIT = 8.
module tb_uart_rx_framer;

    localparam int CPB = 8;

    logic       clkIn;
    logic       resetIn;
    logic       rxIn;
    logic       ackIn;
    logic [7:0] dataOut;
    logic       dataValidOut;
    logic       frameErrorOut;
    logic       overrunErrorOut;
    logic       busyOut;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    int ferr_cnt = 0;
    int oerr_cnt = 0;
    logic prev_valid = 1'b0;

    uart_rx_framer #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clkIn          (clkIn),
        .resetIn        (resetIn),
        .rxIn           (rxIn),
        .ackIn          (ackIn),
        .dataOut        (dataOut),
        .dataValidOut   (dataValidOut),
        .frameErrorOut  (frameErrorOut),
        .overrunErrorOut(overrunErrorOut),
        .busyOut        (busyOut)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    always @(posedge clkIn) cyc = cyc + 1;

    always @(negedge clkIn) begin
        if (frameErrorOut)   ferr_cnt = ferr_cnt + 1;
        if (overrunErrorOut) oerr_cnt = oerr_cnt + 1;
        if (dataValidOut && !prev_valid) rise_cyc = cyc;
        prev_valid = dataValidOut;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clkIn);
        #1;
    endtask

    task automatic ack_pulse();
        ackIn = 1'b1;
        idle(1);
        ackIn = 1'b0;
    endtask

    // Drives one full 10-bit frame; ack_at_stop raises ackIn for exactly
    // the cycle whose edge takes the stop sample.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic ack_at_stop);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            rxIn  = fr[c / CPB];
            ackIn = ack_at_stop && (c == CPB / 2 + 9 * CPB);
            if (c == 0) fall_cyc = cyc;
            idle(1);
        end
        rxIn  = 1'b1;
        ackIn = 1'b0;
    endtask

    int f0, o0;

    initial begin
        resetIn = 1'b1;
        rxIn    = 1'b1;
        ackIn   = 1'b0;
        idle(3);
        check_eq("rst_data",  {24'd0, dataOut}, 32'h00);
        check_eq("rst_valid", {31'd0, dataValidOut}, 32'd0);
        check_eq("rst_busy",  {31'd0, busyOut}, 32'd0);
        resetIn = 1'b0;
        idle(4);

        // Good frame 0xA5, no ack
        f0 = ferr_cnt; o0 = oerr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(2);
        check_eq("a5_data",    {24'd0, dataOut}, 32'hA5);
        check_eq("a5_valid",   {31'd0, dataValidOut}, 32'd1);
        check_eq("a5_latency", rise_cyc - fall_cyc, 32'd77);
        check_eq("a5_ferr",    ferr_cnt - f0, 32'd0);
        check_eq("a5_oerr",    oerr_cnt - o0, 32'd0);
        check_eq("a5_busy",    {31'd0, busyOut}, 32'd0);
        ack_pulse();
        check_eq("ack_clear",  {31'd0, dataValidOut}, 32'd0);

        // 3-cycle glitch
        rxIn = 1'b0;
        idle(3);
        rxIn = 1'b1;
        check_eq("glitch_busy_hi", {31'd0, busyOut}, 32'd1);
        idle(2);
        check_eq("glitch_busy_lo", {31'd0, busyOut}, 32'd0);
        check_eq("glitch_valid",   {31'd0, dataValidOut}, 32'd0);
        check_eq("glitch_data",    {24'd0, dataOut}, 32'hA5);

        // Frame error then stuck-low line
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        rxIn = 1'b0;
        idle(40);
        check_eq("ferr_pulses", ferr_cnt - f0, 32'd1);
        check_eq("ferr_wait_busy", {31'd0, busyOut}, 32'd1);
        check_eq("ferr_valid", {31'd0, dataValidOut}, 32'd0);
        check_eq("ferr_data",  {24'd0, dataOut}, 32'hA5);
        rxIn = 1'b1;
        idle(2);
        check_eq("ferr_released", {31'd0, busyOut}, 32'd0);

        // Overrun
        o0 = oerr_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        idle(2);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(2);
        check_eq("ovr_data",   {24'd0, dataOut}, 32'h11);
        check_eq("ovr_pulses", oerr_cnt - o0, 32'd1);
        check_eq("ovr_valid",  {31'd0, dataValidOut}, 32'd1);
        ack_pulse();
        send_frame(8'h33, 1'b1, 1'b0);
        idle(2);
        check_eq("ovr_next_data",  {24'd0, dataOut}, 32'h33);
        check_eq("ovr_next_valid", {31'd0, dataValidOut}, 32'd1);
        ack_pulse();

        // Back-to-back with ack coincident with second stop sample
        o0 = oerr_cnt;
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h66, 1'b1, 1'b1);
        idle(2);
        check_eq("b2b_data",  {24'd0, dataOut}, 32'h66);
        check_eq("b2b_valid", {31'd0, dataValidOut}, 32'd1);
        check_eq("b2b_oerr",  oerr_cnt - o0, 32'd0);

        // Reset during data bit 4 of 0xFF
        f0 = ferr_cnt; o0 = oerr_cnt;
        rxIn = 1'b0;
        idle(CPB);
        rxIn = 1'b1;
        idle(4 * CPB + 2);
        resetIn = 1'b1;
        #2;
        check_eq("mid_rst_data",  {24'd0, dataOut}, 32'h00);
        check_eq("mid_rst_valid", {31'd0, dataValidOut}, 32'd0);
        check_eq("mid_rst_busy",  {31'd0, busyOut}, 32'd0);
        check_eq("mid_rst_ferr",  {31'd0, frameErrorOut}, 32'd0);
        check_eq("mid_rst_oerr",  {31'd0, overrunErrorOut}, 32'd0);
        idle(1);
        resetIn = 1'b0;
        idle(40);
        check_eq("post_rst_busy", {31'd0, busyOut}, 32'd0);
        check_eq("post_rst_errs", (ferr_cnt - f0) + (oerr_cnt - o0), 32'd0);
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(2);
        check_eq("post_rst_data",  {24'd0, dataOut}, 32'h0F);
        check_eq("post_rst_valid", {31'd0, dataValidOut}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
